// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, types and byte-level helpers for key expansion
package aes_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_KEY_W = 128;

   typedef logic [AES_KEY_W-1:0] round_key_t;

   typedef enum logic {
      ST_IDLE,
      ST_EXPAND
   } ks_state_e;

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box computed as multiplicative inverse (a^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      logic [7:0] s;
      sq  = a;
      inv = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      for (int i = 0; i < 8; i++) begin
         s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
              ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// rtl/aes_key_round_step.sv - combinational single-round AES-128 key expansion step
module aes_key_round_step
   import aes_pkg::*;
(
   input  round_key_t  key_i,
   input  logic [3:0]  round_i,
   output round_key_t  key_o
);

   logic [31:0] t;
   logic [31:0] w0;
   logic [31:0] w1;
   logic [31:0] w2;
   logic [31:0] w3;

   assign t  = sub_word({key_i[23:0], key_i[31:24]}) ^ {rcon(round_i), 24'h000000};
   assign w0 = key_i[127:96] ^ t;
   assign w1 = key_i[95:64]  ^ w0;
   assign w2 = key_i[63:32]  ^ w1;
   assign w3 = key_i[31:0]   ^ w2;

   assign key_o = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// rtl/aes_key_schedule_ctrl.sv - AES-128 key schedule sequencer with 11-entry round-key store (option: KEY_SCHED_ZEROIZE_EN)
module aes_key_schedule_ctrl
   import aes_pkg::*;
#(
   parameter int KEY_W      = 128,
   parameter int NUM_ROUNDS = AES_NR
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [KEY_W-1:0] key_in,
   output logic             busy,
   output logic             done,
   output logic             keys_valid,
   input  logic             rd_en,
   input  logic [3:0]       rd_idx,
   output logic [KEY_W-1:0] rd_data
`ifdef KEY_SCHED_ZEROIZE_EN
   ,
   input  logic             zeroize
`endif
);

   ks_state_e        state_q;
   logic [3:0]       round_q;
   logic             busy_q;
   logic             done_q;
   logic             valid_q;
   logic [KEY_W-1:0] cur_q;
   logic [KEY_W-1:0] rd_data_q;
   logic [KEY_W-1:0] rk_q [0:NUM_ROUNDS];
   round_key_t       step_key_d;

   aes_key_round_step u_step (
      .key_i   (cur_q),
      .round_i (round_q),
      .key_o   (step_key_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         round_q   <= 4'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         cur_q     <= '0;
         rd_data_q <= '0;
         for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
      end else begin
         done_q <= 1'b0;

         // Reads sample the store before this edge's write, so a same-edge read sees the old key
         if (rd_en) begin
            if (rd_idx <= 4'(NUM_ROUNDS)) rd_data_q <= rk_q[rd_idx];
            else                          rd_data_q <= '0;
         end

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  rk_q[0] <= key_in;
                  cur_q   <= key_in;
                  round_q <= 4'd1;
                  busy_q  <= 1'b1;
                  valid_q <= 1'b0;
                  state_q <= ST_EXPAND;
               end
            end
            ST_EXPAND: begin
               rk_q[round_q] <= step_key_d;
               cur_q         <= step_key_d;
               if (round_q == 4'(NUM_ROUNDS)) begin
                  round_q <= 4'd0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  valid_q <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  round_q <= round_q + 4'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

`ifdef KEY_SCHED_ZEROIZE_EN
         // Zeroize overrides everything above, including a start or an in-flight expansion
         if (zeroize) begin
            state_q   <= ST_IDLE;
            round_q   <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            cur_q     <= '0;
            rd_data_q <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
         end
`endif
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign keys_valid = valid_q;
   assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb/tb_aes_key_schedule_ctrl.sv - self-checking bench for aes_key_schedule_ctrl
module tb_aes_key_schedule_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic         rd_en;
   logic [3:0]   rd_idx;
   logic [127:0] rd_data;
`ifdef KEY_SCHED_ZEROIZE_EN
   logic         zeroize;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   aes_key_schedule_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .key_in     (key_in),
      .busy       (busy),
      .done       (done),
      .keys_valid (keys_valid),
      .rd_en      (rd_en),
      .rd_idx     (rd_idx),
      .rd_data    (rd_data)
`ifdef KEY_SCHED_ZEROIZE_EN
      ,
      .zeroize    (zeroize)
`endif
   );

   // Reference model: GF(2^8) via exp/log tables and the word recurrence w[i]=w[i-4]^f(w[i-1])
   logic [7:0]   exp_t [0:255];
   logic [7:0]   log_t [0:255];
   logic [7:0]   rc_t  [1:10];
   logic [127:0] m_rk  [0:10];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   task automatic build_tables();
      logic [7:0] e;
      e = 8'h01;
      for (int i = 0; i < 255; i++) begin
         exp_t[i] = e;
         log_t[e] = 8'(i);
         e = e ^ xt(e);
      end
      e = 8'h01;
      for (int j = 1; j <= 10; j++) begin
         rc_t[j] = e;
         e = xt(e);
      end
   endtask

   function automatic logic [7:0] sbox_m(input logic [7:0] a);
      logic [7:0] inv;
      inv = (a == 8'h00) ? 8'h00 : exp_t[(255 - int'(log_t[a])) % 255];
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
   endfunction

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] tmp;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_m(tmp[31:24]), sbox_m(tmp[23:16]), sbox_m(tmp[15:8]), sbox_m(tmp[7:0])};
            tmp = tmp ^ {rc_t[i/4], 24'h0};
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r <= 10; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic read_key(input logic [3:0] idx, output logic [127:0] data);
      @(negedge clk);
      rd_en  = 1'b1;
      rd_idx = idx;
      @(negedge clk);
      rd_en  = 1'b0;
      data   = rd_data;
   endtask

   task automatic wait_done(inout int lat);
      while (!done && lat < 30) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_expand(input logic [127:0] key, output int lat);
      @(negedge clk);
      start  = 1'b1;
      key_in = key;
      @(negedge clk);
      start  = 1'b0;
      lat    = 0;
      wait_done(lat);
   endtask

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] exp;
   } vec_t;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   initial begin
      vec_t         t1 [6];
      logic [127:0] d;
      logic [127:0] d2;
      logic [127:0] key_a;
      logic [127:0] old_rk1;
      int           lat;

      t1[0] = '{4'd0,  FIPS_KEY};
      t1[1] = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
      t1[2] = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
      t1[3] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      t1[4] = '{4'd11, 128'h0};
      t1[5] = '{4'd15, 128'h0};

      build_tables();
      reset  = 1'b1;
      start  = 1'b0;
      key_in = '0;
      rd_en  = 1'b0;
      rd_idx = 4'd0;
`ifdef KEY_SCHED_ZEROIZE_EN
      zeroize = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_done", 128'(done), 128'(0));
      check("reset_valid", 128'(keys_valid), 128'(0));
      check("reset_rd_data", rd_data, 128'h0);
      reset = 1'b0;

      // T1: FIPS-197 key, table-driven reads
      run_expand(FIPS_KEY, lat);
      check("t1_latency", 128'(lat), 128'(10));
      check("t1_valid", 128'(keys_valid), 128'(1));
      for (int i = 0; i < 6; i++) begin
         read_key(t1[i].idx, d);
         check($sformatf("t1_rk%0d", t1[i].idx), d, t1[i].exp);
      end
      check("t1_done_pulse", 128'(done), 128'(0));
      read_key(4'd1, d);
      @(negedge clk);
      rd_idx = 4'd10;
      @(negedge clk);
      check("hold_rd_data", rd_data, t1[1].exp);

      // T2: start during expansion is ignored
      @(negedge clk);
      start  = 1'b1;
      key_in = FIPS_KEY;
      @(negedge clk);
      start  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start  = 1'b1;
      key_in = 128'h00112233445566778899aabbccddeeff;
      @(negedge clk);
      start  = 1'b0;
      lat    = 3;
      wait_done(lat);
      check("t2_latency", 128'(lat), 128'(10));
      read_key(4'd1, d);
      check("t2_rk1", d, t1[1].exp);
      read_key(4'd10, d);
      check("t2_rk10", d, t1[3].exp);

      // T3: all-zero key
      run_expand(128'h0, lat);
      check("t3_latency", 128'(lat), 128'(10));
      read_key(4'd1, d);
      check("t3_rk1", d, 128'h62636363626363636263636362636363);
      read_key(4'd11, d);
      check("t3_rk11", d, 128'h0);
      read_key(4'd15, d);
      check("t3_rk15", d, 128'h0);

      // Randomized keys against the reference model
      for (int k = 0; k < 4; k++) begin
         key_a = {$urandom, $urandom, $urandom, $urandom};
         model_expand(key_a);
         run_expand(key_a, lat);
         check($sformatf("rnd%0d_latency", k), 128'(lat), 128'(10));
         check($sformatf("rnd%0d_valid", k), 128'(keys_valid), 128'(1));
         for (int r = 0; r <= 10; r++) begin
            read_key(4'(r), d);
            check($sformatf("rnd%0d_rk%0d", k, r), d, m_rk[r]);
         end
      end

      // T5: back-to-back start in the done cycle; same-edge read returns old rk1
      key_a = {$urandom, $urandom, $urandom, $urandom};
      model_expand(key_a);
      old_rk1 = m_rk[1];
      run_expand(key_a, lat);
      check("t5_first_done", 128'(done), 128'(1));
      start  = 1'b1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      d2     = key_in;
      @(negedge clk);
      start  = 1'b0;
      check("t5_valid_cleared", 128'(keys_valid), 128'(0));
      check("t5_busy", 128'(busy), 128'(1));
      rd_en  = 1'b1;
      rd_idx = 4'd1;
      @(negedge clk);
      rd_en  = 1'b0;
      check("t5_read_on_write_edge", rd_data, old_rk1);
      lat = 1;
      wait_done(lat);
      check("t5_latency", 128'(lat), 128'(10));
      model_expand(d2);
      for (int r = 0; r <= 10; r += 5) begin
         read_key(4'(r), d);
         check($sformatf("t5_rk%0d", r), d, m_rk[r]);
      end

      // T4: reset mid-expansion
      @(negedge clk);
      start  = 1'b1;
      key_in = FIPS_KEY;
      @(negedge clk);
      start  = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      check("t4_busy", 128'(busy), 128'(0));
      check("t4_valid", 128'(keys_valid), 128'(0));
      check("t4_rd_data", rd_data, 128'h0);
      @(negedge clk);
      reset = 1'b0;
      read_key(4'd0, d);
      check("t4_rk0", d, 128'h0);
      @(negedge clk);
      check("t4_done", 128'(done), 128'(0));

`ifdef KEY_SCHED_ZEROIZE_EN
      // T6: zeroize
      run_expand(FIPS_KEY, lat);
      check("t6_latency", 128'(lat), 128'(10));
      @(negedge clk);
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
      check("t6_valid", 128'(keys_valid), 128'(0));
      check("t6_rd_data", rd_data, 128'h0);
      for (int r = 0; r <= 10; r++) begin
         read_key(4'(r), d);
         check($sformatf("t6_rk%0d", r), d, 128'h0);
      end
      @(negedge clk);
      start   = 1'b1;
      zeroize = 1'b1;
      key_in  = FIPS_KEY;
      @(negedge clk);
      start   = 1'b0;
      zeroize = 1'b0;
      check("t6_start_busy", 128'(busy), 128'(0));
      repeat (12) @(negedge clk);
      check("t6_start_valid", 128'(keys_valid), 128'(0));
      read_key(4'd0, d);
      check("t6_start_rk0", d, 128'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
